apb4_clint_mh: RTL

Multi-hart, parametrised core-local interruptor on the APB4 peripheral bus. It provides:
- one shared 64-bit `mtime` counter, advanced by a synchronised, prescaled `rtc_clk_i`;
- a per-hart 64-bit `mtimecmp`, software-interrupt bit and timer-interrupt output.

It generalises the single-hart CLINT with:
- a configurable hart count;
- full 64-bit compare writes;
- a tear-free `mtime` read;
- an APB error response for unmapped offsets.

---
 rtl/apb4_clint_mh_if.sv | 24 ++
 rtl/apb4_clint_mh.sv | 152 +++++++++++++++
 2 files changed

// File: rtl/apb4_clint_mh_if.sv
// APB4 slave bus bundle for the multi-hart CLINT, including its clock and reset.
// The master modport drives clock, reset and requests; the slave returns data and status.
interface apb4_clint_mh_if;
  logic        hclk;
  logic        hresetn;
  logic [31:0] paddr;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslerr;

  modport master (
    output hclk, hresetn, paddr, psel, penable, pwrite, pwdata,
    input  prdata, pready, pslerr
  );

  modport slave (
    input  hclk, hresetn, paddr, psel, penable, pwrite, pwdata,
    output prdata, pready, pslerr
  );
endinterface

// File: rtl/apb4_clint_mh.sv
// Multi-hart CLINT on APB4: shared mtime, per-hart mtimecmp/MSIP; CLINT_MTIME_WR_EN makes mtime writable.
// Zero-wait APB (pready=1), combinational read data; rtc edge reaches mtime after 4 hclk edges.
module apb4_clint_mh #(
  parameter int HART_NUM   = 4,
  parameter int PSCR_WIDTH = 16
) (
  apb4_clint_mh_if.slave      apb4,
  input  logic                rtc_clk_i,
  output logic [HART_NUM-1:0] tmr_irq_o,
  output logic [HART_NUM-1:0] sfr_irq_o
);

  logic [4:0] idx;
  logic       acc, wr_acc, rd_acc;
  logic       is_ctrl, is_pscr, is_mtl, is_mth;
  logic       msip_hit, msip_ok, cmp_ok;
  logic [2:0] msip_h, cmp_h;
  logic       cmp_hi, mapped;
  logic [31:0] rdata;
  logic       unused_paddr;

  logic                       ctrl_en_q, ctrl_en_d;
  logic [PSCR_WIDTH-1:0]      pscr_q, pscr_d;
  logic [PSCR_WIDTH-1:0]      pcnt_q, pcnt_d;
  logic [63:0]                mtime_q, mtime_d;
  logic [31:0]                shadow_q, shadow_d;
  logic [HART_NUM-1:0]        msip_q, msip_d;
  logic [HART_NUM-1:0][63:0]  cmp_q, cmp_d;
  logic [HART_NUM-1:0]        tmr_q, tmr_d;
  logic [2:0]                 rtc_sync_q, rtc_sync_d;
  logic                       tick_q, tick_d;
  logic                       mtime_inc;

  assign unused_paddr = ^{apb4.paddr[31:7], apb4.paddr[1:0]};

  assign idx    = apb4.paddr[6:2];
  assign acc    = apb4.psel & apb4.penable;
  assign wr_acc = acc & apb4.pwrite;
  assign rd_acc = acc & ~apb4.pwrite;

  always_comb begin
    is_ctrl  = (idx == 5'd0);
    is_pscr  = (idx == 5'd1);
    is_mtl   = (idx == 5'd2);
    is_mth   = (idx == 5'd3);
    msip_hit = (idx >= 5'd4) && (idx <= 5'd11);
    msip_h   = 3'(idx - 5'd4);
    cmp_h    = idx[3:1];
    cmp_hi   = idx[0];
    msip_ok  = msip_hit && (int'(msip_h) < HART_NUM);
    cmp_ok   = idx[4] && (int'(cmp_h) < HART_NUM);
    mapped   = is_ctrl | is_pscr | is_mtl | is_mth | msip_ok | cmp_ok;
  end

  always_comb begin
    rdata = '0;
    if (is_ctrl) rdata = {31'b0, ctrl_en_q};
    if (is_pscr) rdata = 32'(pscr_q);
    if (is_mtl)  rdata = mtime_q[31:0];
    if (is_mth)  rdata = shadow_q;
    for (int h = 0; h < HART_NUM; h++) begin
      if (msip_ok && msip_h == 3'(h)) rdata = {31'b0, msip_q[h]};
      if (cmp_ok && cmp_h == 3'(h))   rdata = cmp_hi ? cmp_q[h][63:32] : cmp_q[h][31:0];
    end
  end

  assign apb4.prdata = (rd_acc && mapped) ? rdata : '0;
  assign apb4.pslerr = acc & ~mapped;
  assign apb4.pready = 1'b1;

  // Stages 0/1 synchronise rtc_clk_i; stage 2 holds the previous value for edge detection.
  always_comb begin
    rtc_sync_d = {rtc_sync_q[1:0], rtc_clk_i};
    tick_d     = rtc_sync_q[1] & ~rtc_sync_q[2];
  end

  always_comb begin
    ctrl_en_d = ctrl_en_q;
    pscr_d    = pscr_q;
    pcnt_d    = pcnt_q;
    shadow_d  = shadow_q;
    msip_d    = msip_q;
    cmp_d     = cmp_q;
    mtime_inc = 1'b0;

    if (wr_acc && is_ctrl) ctrl_en_d = apb4.pwdata[0];

    // A PSCR write swallows a coincident tick; ticks use EN as it was before any same-cycle write.
    if (wr_acc && is_pscr) begin
      pscr_d = apb4.pwdata[PSCR_WIDTH-1:0];
      pcnt_d = '0;
    end else if (tick_q && ctrl_en_q) begin
      if (pcnt_q == pscr_q) begin
        pcnt_d    = '0;
        mtime_inc = 1'b1;
      end else begin
        pcnt_d = pcnt_q + PSCR_WIDTH'(1);
      end
    end

    mtime_d = mtime_inc ? mtime_q + 64'd1 : mtime_q;
`ifdef CLINT_MTIME_WR_EN
    if (wr_acc && is_mtl) mtime_d = {mtime_q[63:32], apb4.pwdata};
    if (wr_acc && is_mth) mtime_d = {apb4.pwdata, mtime_q[31:0]};
`endif

    if (rd_acc && is_mtl) shadow_d = mtime_q[63:32];

    for (int h = 0; h < HART_NUM; h++) begin
      if (wr_acc && msip_ok && msip_h == 3'(h)) msip_d[h] = apb4.pwdata[0];
      if (wr_acc && cmp_ok && cmp_h == 3'(h)) begin
        if (cmp_hi) cmp_d[h][63:32] = apb4.pwdata;
        else        cmp_d[h][31:0]  = apb4.pwdata;
      end
    end
  end

  always_comb begin
    tmr_d = '0;
    for (int h = 0; h < HART_NUM; h++) tmr_d[h] = (mtime_q >= cmp_q[h]);
  end

  always_ff @(posedge apb4.hclk or negedge apb4.hresetn) begin
    if (!apb4.hresetn) begin
      ctrl_en_q  <= 1'b1;
      pscr_q     <= '0;
      pcnt_q     <= '0;
      mtime_q    <= '0;
      shadow_q   <= '0;
      msip_q     <= '0;
      cmp_q      <= '1;
      tmr_q      <= '0;
      rtc_sync_q <= '0;
      tick_q     <= 1'b0;
    end else begin
      ctrl_en_q  <= ctrl_en_d;
      pscr_q     <= pscr_d;
      pcnt_q     <= pcnt_d;
      mtime_q    <= mtime_d;
      shadow_q   <= shadow_d;
      msip_q     <= msip_d;
      cmp_q      <= cmp_d;
      tmr_q      <= tmr_d;
      rtc_sync_q <= rtc_sync_d;
      tick_q     <= tick_d;
    end
  end

  assign tmr_irq_o = tmr_q;
  assign sfr_irq_o = msip_q;

endmodule
